// File: rtl/hs_ram_arbiter_if.sv
// Hiscore engine <-> work-RAM arbiter handshake bundle.
// master: hiscore engine side; slave: arbiter side.
interface hs_ram_arbiter_if #(
  parameter int unsigned ADDR_W = 12
) ();
  logic              hs_req;
  logic [ADDR_W-1:0] hs_addr;
  logic [7:0]        hs_wdata;
  logic              hs_we;
  logic              hs_grant;
  logic [7:0]        hs_rdata;

  modport master (
    output hs_req, hs_addr, hs_wdata, hs_we,
    input  hs_grant, hs_rdata
  );

  modport slave (
    input  hs_req, hs_addr, hs_wdata, hs_we,
    output hs_grant, hs_rdata
  );
endinterface

// File: rtl/hs_ram_arbiter.sv
// Work-RAM arbiter: halts the game CPU, waits for the bus to settle, then
// hands the shared RAM port to the hiscore engine. A watchdog bounds the
// grant length; after expiry the engine must drop its request once before
// it can be granted again.
module hs_ram_arbiter #(
  parameter int unsigned ADDR_W        = 12,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned DRAIN_CYCLES  = 2,
  parameter int unsigned GRANT_TIMEOUT = 4096
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              user_pause,
  hs_ram_arbiter_if.slave   hs,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  input  logic              cpu_we,
  output logic [7:0]        cpu_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  input  logic [7:0]        ram_rdata,
  output logic              pause_cpu,
  output logic              timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_SETTLE,
    S_GRANT,
    S_DRAIN
  } state_t;

  localparam logic [3:0]  SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0]  DRAIN_LOAD  = 4'(DRAIN_CYCLES - 1);
  localparam logic [15:0] WD_LAST     = 16'(GRANT_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] wd_q, wd_d;
  logic        lock_q, lock_d;
  logic        grant_q;
  logic        pause_q;

  // State, counters and registered outputs
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wd_q    <= '0;
      lock_q  <= 1'b0;
      grant_q <= 1'b0;
      pause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      lock_q  <= lock_d;
      grant_q <= (state_d == S_GRANT);
      pause_q <= (state_d != S_IDLE) || user_pause;
    end
  end

  // Next-state, counter and watchdog logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    lock_d  = lock_q;
    timeout = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // A lockout left by a watchdog expiry is released only by a low request.
        if (lock_q) begin
          if (!hs.hs_req) lock_d = 1'b0;
        end else if (hs.hs_req) begin
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        if (!hs.hs_req) begin
          state_d = S_DRAIN;
          cnt_d   = DRAIN_LOAD;
        end else begin
          state_d = S_SETTLE;
          cnt_d   = SETTLE_LOAD;
        end
      end
      S_SETTLE: begin
        if (!hs.hs_req) begin
          state_d = S_DRAIN;
          cnt_d   = DRAIN_LOAD;
        end else if (cnt_q == '0) begin
          state_d = S_GRANT;
          wd_d    = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_GRANT: begin
        if (wd_q != '1) wd_d = wd_q + 16'd1;
        if (!hs.hs_req) begin
          state_d = S_DRAIN;
          cnt_d   = DRAIN_LOAD;
        end else if (wd_q == WD_LAST) begin
          state_d = S_DRAIN;
          cnt_d   = DRAIN_LOAD;
          lock_d  = 1'b1;
          timeout = 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // RAM port mux driven from the registered state
  always_comb begin
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    ram_we    = 1'b0;
    unique case (state_q)
      S_GRANT: begin
        ram_addr  = hs.hs_addr;
        ram_wdata = hs.hs_wdata;
        ram_we    = hs.hs_we;
      end
      S_IDLE:  ram_we = cpu_we;
      default: ram_we = 1'b0;
    endcase
    if (!reset_n) ram_we = 1'b0;
  end

  assign hs.hs_grant = grant_q;
  assign hs.hs_rdata = ram_rdata;
  assign cpu_rdata   = ram_rdata;
  assign pause_cpu   = pause_q;

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// Bench for hs_ram_arbiter: scripted sequencing checks plus a read-data
// scoreboard against a reference copy of the work RAM.
module tb_hs_ram_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        user_pause;
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic [7:0]  cpu_rdata;
  logic [11:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata;
  logic        pause_cpu;
  logic        timeout;

  hs_ram_arbiter_if #(.ADDR_W(12)) hs_bus ();

  hs_ram_arbiter #(
    .ADDR_W        (12),
    .SETTLE_CYCLES (4),
    .DRAIN_CYCLES  (2),
    .GRANT_TIMEOUT (8)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .user_pause (user_pause),
    .hs         (hs_bus),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_we     (cpu_we),
    .cpu_rdata  (cpu_rdata),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .ram_rdata  (ram_rdata),
    .pause_cpu  (pause_cpu),
    .timeout    (timeout)
  );

  always #5 clk_sys = ~clk_sys;

  // Work RAM attached to the arbiter, 1-cycle read latency
  logic [7:0] mem     [0:4095];
  logic [7:0] ref_mem [0:4095];
  always @(posedge clk_sys) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [7:0]  exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic cpu_read(input logic [11:0] a);
    cpu_we   = 1'b0;
    cpu_addr = a;
    exp_q.push_back(ref_mem[a]);
    tick();
    chk("cpu_rdata", 32'(cpu_rdata), 32'(exp_q.pop_front()));
  endtask

  task automatic hs_read(input logic [11:0] a);
    hs_bus.hs_we   = 1'b0;
    hs_bus.hs_addr = a;
    exp_q.push_back(ref_mem[a]);
    tick();
    chk("hs_rdata", 32'(hs_bus.hs_rdata), 32'(exp_q.pop_front()));
    chk("hs_grant_rd", 32'(hs_bus.hs_grant), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
    reset_n          = 1'b0;
    user_pause       = 1'b0;
    cpu_addr         = 12'h000;
    cpu_wdata        = 8'h00;
    cpu_we           = 1'b1;
    hs_bus.hs_req    = 1'b0;
    hs_bus.hs_addr   = '0;
    hs_bus.hs_wdata  = 8'h00;
    hs_bus.hs_we     = 1'b0;
    tick();
    tick();
    chk("rst_grant", 32'(hs_bus.hs_grant), 32'd0);
    chk("rst_pause", 32'(pause_cpu), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);

    // Held request: halt at cycle 1, grant at cycle 6
    cpu_we         = 1'b0;
    cpu_addr       = 12'h7FF;
    reset_n        = 1'b1;
    hs_bus.hs_req  = 1'b1;
    hs_bus.hs_addr = 12'h040;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("seq_pause", 32'(pause_cpu), 32'd1);
      chk("seq_grant", 32'(hs_bus.hs_grant), 32'(i == 6));
      chk("seq_ram_addr", 32'(ram_addr), (i == 6) ? 32'h040 : 32'h7FF);
      chk("seq_ram_we", 32'(ram_we), 32'd0);
    end
    chk("seq_timeout", 32'(timeout), 32'd0);

    // Hiscore write then read-back in GRANT
    hs_bus.hs_addr  = 12'h123;
    hs_bus.hs_wdata = 8'hA5;
    hs_bus.hs_we    = 1'b1;
    #1;
    chk("wr_ram_we", 32'(ram_we), 32'd1);
    chk("wr_ram_addr", 32'(ram_addr), 32'h123);
    chk("wr_ram_wdata", 32'(ram_wdata), 32'hA5);
    ref_mem[12'h123] = 8'hA5;
    tick();
    hs_read(12'h123);
    hs_read(12'h040);

    // Drop request: pause falls DRAIN_CYCLES+1 cycles later
    hs_bus.hs_req = 1'b0;
    cpu_we        = 1'b1;
    cpu_addr      = 12'h7FF;
    cpu_wdata     = 8'h3C;
    for (int j = 1; j <= 3; j++) begin
      tick();
      chk("drop_pause", 32'(pause_cpu), 32'(j < 3));
      chk("drop_grant", 32'(hs_bus.hs_grant), 32'd0);
      chk("drop_ram_we", 32'(ram_we), 32'(j >= 3));
    end
    ref_mem[12'h7FF] = 8'h3C;
    tick();
    cpu_read(12'h7FF);

    // Two-cycle request aborts in SETTLE
    hs_bus.hs_addr = 12'h200;
    hs_bus.hs_we   = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      hs_bus.hs_req = (k <= 2);
      tick();
      chk("abort_pause", 32'(pause_cpu), 32'(k < 5));
      chk("abort_grant", 32'(hs_bus.hs_grant), 32'd0);
      chk("abort_ram_we", 32'(ram_we), 32'd0);
    end
    hs_bus.hs_we = 1'b0;
    cpu_read(12'h200);

    // Watchdog expiry and lockout until the request drops once
    for (int k = 1; k <= 27; k++) begin
      hs_bus.hs_req = (k != 21);
      tick();
      chk("wd_timeout", 32'(timeout), 32'(k == 13));
      chk("wd_grant", 32'(hs_bus.hs_grant), 32'((k >= 6 && k <= 13) || k >= 27));
      chk("wd_pause", 32'(pause_cpu), 32'(k <= 15 || k >= 22));
    end

    // Reset in the middle of a grant with a hiscore write pending
    hs_bus.hs_we    = 1'b1;
    hs_bus.hs_addr  = 12'h300;
    hs_bus.hs_wdata = 8'h77;
    cpu_we          = 1'b1;
    cpu_addr        = 12'h7F0;
    cpu_wdata       = 8'h11;
    reset_n         = 1'b0;
    tick();
    chk("mrst_ram_we_in_reset", 32'(ram_we), 32'd0);
    reset_n       = 1'b1;
    hs_bus.hs_req = 1'b0;
    #1;
    chk("mrst_grant", 32'(hs_bus.hs_grant), 32'd0);
    chk("mrst_pause", 32'(pause_cpu), 32'd0);
    chk("mrst_timeout", 32'(timeout), 32'd0);
    chk("mrst_ram_we", 32'(ram_we), 32'd1);
    chk("mrst_ram_addr", 32'(ram_addr), 32'h7F0);
    ref_mem[12'h7F0] = 8'h11;
    tick();
    hs_bus.hs_we = 1'b0;
    cpu_read(12'h300);
    cpu_read(12'h7F0);

    // User pause in IDLE: delayed pause, CPU keeps the RAM
    user_pause = 1'b1;
    cpu_we     = 1'b1;
    cpu_addr   = 12'h7E0;
    cpu_wdata  = 8'h99;
    #1;
    chk("up_ram_we0", 32'(ram_we), 32'd1);
    chk("up_pause0", 32'(pause_cpu), 32'd0);
    ref_mem[12'h7E0] = 8'h99;
    for (int k = 1; k <= 2; k++) begin
      tick();
      chk("up_pause", 32'(pause_cpu), 32'd1);
      chk("up_grant", 32'(hs_bus.hs_grant), 32'd0);
      chk("up_ram_we", 32'(ram_we), 32'd1);
    end

    // Hiscore request while user pause is held
    for (int k = 1; k <= 9; k++) begin
      hs_bus.hs_req = (k <= 6);
      tick();
      chk("upreq_pause", 32'(pause_cpu), 32'd1);
      chk("upreq_grant", 32'(hs_bus.hs_grant), 32'(k == 6));
      chk("upreq_ram_we", 32'(ram_we), 32'(k == 9));
    end
    cpu_read(12'h7E0);
    cpu_read(12'h123);
    chk("end_pause", 32'(pause_cpu), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hs_ram_arbiter.md
HS_RAM_ARBITER -- requirements
Module: hs_ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12: work-RAM address width.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 4: cycles from pause assertion to grant (range 1-15).
REQ-003 SHALL have parameter DRAIN_CYCLES, default 2: cycles pause is held after release (range 1-15).
REQ-004 SHALL have parameter GRANT_TIMEOUT, default 4096: maximum consecutive GRANT cycles (range 2-65535).
REQ-005 SHALL have port clk_sys, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port reset_n, input, 1: reset, synchronous, active-low.
REQ-007 SHALL have port user_pause, input, 1: pause request from the OSD/user pause logic.
REQ-008 SHALL have ports hs_req (in, 1), hs_addr (in, ADDR_W), hs_wdata (in, 8), hs_we (in, 1), hs_grant (out, 1), hs_rdata (out, 8): hiscore engine side.
REQ-009 SHALL have ports cpu_addr (in, ADDR_W), cpu_wdata (in, 8), cpu_we (in, 1), cpu_rdata (out, 8): game CPU side.
REQ-010 SHALL have ports ram_addr (out, ADDR_W), ram_wdata (out, 8), ram_we (out, 1), ram_rdata (in, 8): shared work-RAM port; RAM read latency is 1 cycle.
REQ-011 SHALL have port pause_cpu, output, 1: CPU halt.
REQ-012 SHALL have port timeout, output, 1: one-cycle pulse on grant watchdog expiry.

Function
REQ-013 SHALL implement states IDLE, HALT, SETTLE, GRANT, DRAIN.
REQ-014 IDLE: hs_req=1 -> HALT next cycle; otherwise stay.
REQ-015 HALT: lasts exactly 1 cycle -> SETTLE; settle counter loaded with SETTLE_CYCLES-1.
REQ-016 SETTLE: counter decrements each cycle; at 0 -> GRANT; hs_req=0 at any SETTLE/HALT cycle -> DRAIN (abort, no grant).
REQ-017 GRANT: hs_grant=1 (registered, asserted from first GRANT cycle); hs_req=0 -> DRAIN next cycle.
REQ-018 DRAIN: counter loaded with DRAIN_CYCLES-1, decrements, at 0 -> IDLE; hs_req ignored during DRAIN.
REQ-019 pause_cpu SHALL be registered: 1 in HALT, SETTLE, GRANT, DRAIN; in IDLE equals user_pause delayed one cycle.
REQ-020 ram_addr/ram_wdata SHALL select hs_* in GRANT, cpu_* in all other states (combinational mux on registered state).
REQ-021 ram_we SHALL be hs_we in GRANT, cpu_we in IDLE, 0 in HALT, SETTLE, DRAIN.
REQ-022 cpu_rdata and hs_rdata SHALL both equal ram_rdata; hs_rdata valid 1 cycle after a GRANT-state address.
REQ-023 Grant watchdog: 16-bit counter cleared on GRANT entry, increments per GRANT cycle; reaching GRANT_TIMEOUT-1 with hs_req still 1 -> DRAIN and timeout=1 for that single cycle; counter saturates, never wraps.
REQ-024 After timeout, hs_req SHALL be deasserted for at least one cycle (observed in IDLE) before a new HALT is entered.
REQ-025 user_pause asserted during non-IDLE states SHALL have no effect on sequencing; pause_cpu remains 1 on return to IDLE if user_pause=1.
REQ-026 hs_req and user_pause rising in the same cycle from IDLE -> HALT; arbitration favours hiscore.

Reset
REQ-027 reset_n=0 sampled at a clock edge SHALL force state IDLE, counters 0, hs_grant=0, pause_cpu=0, timeout=0, timeout-lockout cleared, from the next cycle, including mid-GRANT.
REQ-028 While in reset ram_we SHALL be 0.

Verification
REQ-029 Reset, hs_req=1 held: pause_cpu=1 at cycle 1, hs_grant=1 at cycle 1+1+SETTLE_CYCLES (cycle 6 with defaults); ram_addr tracks hs_addr from that cycle.
REQ-030 In GRANT write hs_addr=0x123, hs_wdata=0xA5, hs_we=1; drop hs_req -> ram_we=0 after; pause_cpu falls exactly DRAIN_CYCLES+1 cycles after hs_req drop.
REQ-031 hs_req pulsed for 2 cycles (abort in SETTLE): hs_grant never 1, ram_we never 1 from hs side, return to IDLE after DRAIN.
REQ-032 GRANT_TIMEOUT=8, hs_req held: timeout pulses once on 8th GRANT cycle, hs_grant falls next cycle, no re-grant until hs_req low for 1 cycle.
REQ-033 reset_n=0 mid-GRANT with hs_we=1: next cycle hs_grant=0, pause_cpu=0, ram_we=cpu_we.
REQ-034 IDLE with user_pause=1, cpu_we=1: pause_cpu=1 one cycle later, ram_we follows cpu_we, no state change.
